// File: rtl/axis_row_packer.sv
// Re-frames an AXI-Stream into fixed ROW_WORDS-word rows (tlast per row), zero-padding ragged frames.
// Latency 1 cycle; one output register, input stalls while it is full or while pad words are emitted.
module axis_row_packer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ROW_WORDS  = 36,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [CNT_WIDTH-1:0]    rows_done,
  output logic [CNT_WIDTH-1:0]    pad_words,
  output logic                    padding
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  logic [0:0] state;
  logic [7:0] word_idx;
  logic       out_free;
  logic       in_hs;
  logic       out_hs;
  logic       last_idx;
  logic [7:0] next_idx;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_PASS) && out_free && aresetn;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign last_idx      = (word_idx == 8'(ROW_WORDS - 1));
  assign next_idx      = last_idx ? 8'd0 : word_idx + 8'd1;
  assign padding       = (state == ST_PAD);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_PASS;
      word_idx      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tstrb  <= '0;
      rows_done     <= '0;
      pad_words     <= '0;
    end else begin
      if (out_hs && m_axis_tlast) begin
        rows_done <= rows_done + 1'b1;
      end

      if (state == ST_PASS) begin
        if (in_hs) begin
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tstrb  <= {STRB_W{1'b1}};
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= last_idx;
          word_idx      <= next_idx;
          // A frame ending mid-row leaves the row open; pad words close it.
          if (s_axis_tlast && !last_idx) begin
            state <= ST_PAD;
          end
        end else if (out_hs) begin
          m_axis_tvalid <= 1'b0;
        end
      end else begin
        if (out_free) begin
          m_axis_tdata  <= PAD_WORD;
          m_axis_tstrb  <= '0;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= last_idx;
          word_idx      <= next_idx;
          pad_words     <= pad_words + 1'b1;
          if (last_idx) begin
            state <= ST_PASS;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_row_packer.sv
// Directed bench for axis_row_packer with ROW_WORDS=4: framing, padding, backpressure, reset.
module tb_axis_row_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tstrb;
  logic [15:0] rows_done;
  logic [15:0] pad_words;
  logic        padding;

  int checks = 0;
  int errors = 0;
  int pad_cycles;
  int run_cycles;
  int exp_rows;
  int exp_pads;

  logic [31:0] in_d[$];
  bit          in_l[$];
  logic [31:0] ex_d[$];
  bit          ex_l[$];
  logic [3:0]  ex_s[$];

  always #5 aclk = ~aclk;

  axis_row_packer #(
    .DATA_WIDTH(32),
    .ROW_WORDS (4),
    .PAD_WORD  (32'h0),
    .CNT_WIDTH (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tstrb (m_axis_tstrb),
    .rows_done    (rows_done),
    .pad_words    (pad_words),
    .padding      (padding)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_in(input logic [31:0] d, input bit l);
    in_d.push_back(d);
    in_l.push_back(l);
  endtask

  task automatic push_ex(input logic [31:0] d, input bit l, input logic [3:0] s);
    ex_d.push_back(d);
    ex_l.push_back(l);
    ex_s.push_back(s);
  endtask

  // Drives in_* and scores outputs against ex_*; entered and left at posedge+1.
  task automatic run(input bit rnd, input int budget);
    bit          stalled = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic [3:0]  ps = '0;
    int          cyc = 0;
    pad_cycles = 0;
    while (1) begin
      s_axis_tvalid = (in_d.size() > 0);
      s_axis_tdata  = (in_d.size() > 0) ? in_d[0] : 32'h0;
      s_axis_tlast  = (in_d.size() > 0) ? in_l[0] : 1'b0;
      m_axis_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge aclk);
      cyc++;
      if (stalled) begin
        check("stall_vld", m_axis_tvalid, 1);
        check("stall_dat", m_axis_tdata, pd);
        check("stall_last", m_axis_tlast, pl);
        check("stall_strb", m_axis_tstrb, ps);
      end
      if (padding) begin
        pad_cycles++;
        check("pad_rdy", s_axis_tready, 0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("out_expected", ex_d.size() > 0, 1);
        if (ex_d.size() > 0) begin
          check("out_dat", m_axis_tdata, ex_d.pop_front());
          check("out_last", m_axis_tlast, ex_l.pop_front());
          check("out_strb", m_axis_tstrb, ex_s.pop_front());
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        void'(in_d.pop_front());
        void'(in_l.pop_front());
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      ps = m_axis_tstrb;
      if (in_d.size() == 0 && ex_d.size() == 0) break;
      if (cyc >= budget) begin
        checks++;
        errors++;
        $error("FAIL run_timeout cycles=%0d pending_in=%0d pending_out=%0d", cyc, in_d.size(), ex_d.size());
        in_d.delete(); in_l.delete(); ex_d.delete(); ex_l.delete(); ex_s.delete();
        break;
      end
      @(posedge aclk);
      #1;
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    run_cycles    = cyc;
  endtask

  initial begin
    int idx;
    bit l;
    logic [31:0] d;

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_vld", m_axis_tvalid, 0);
    check("rst_last", m_axis_tlast, 0);
    check("rst_dat", m_axis_tdata, 0);
    check("rst_strb", m_axis_tstrb, 0);
    check("rst_rows", rows_done, 0);
    check("rst_pads", pad_words, 0);
    check("rst_padding", padding, 0);
    check("rst_rdy", s_axis_tready, 0);
    aresetn = 1'b1;
    #1;
    check("post_rst_rdy", s_axis_tready, 1);
    @(posedge aclk);
    #1;

    // Two full rows from one frame, no padding
    for (int i = 1; i <= 8; i++) begin
      push_in(32'(i), i == 8);
      push_ex(32'(i), (i % 4) == 0, 4'hF);
    end
    run(1'b0, 100);
    check("t1_rows", rows_done, 2);
    check("t1_pads", pad_words, 0);
    check("t1_padcyc", pad_cycles, 0);

    // Five-word frame pads three words
    for (int i = 0; i < 5; i++) push_in(32'hA + 32'(i), i == 4);
    push_ex(32'hA, 0, 4'hF); push_ex(32'hB, 0, 4'hF); push_ex(32'hC, 0, 4'hF); push_ex(32'hD, 1, 4'hF);
    push_ex(32'hE, 0, 4'hF); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 1, 4'h0);
    run(1'b0, 100);
    check("t2_rows", rows_done, 4);
    check("t2_pads", pad_words, 3);
    check("t2_padcyc", pad_cycles, 3);

    // Single-word frame, then a two-word frame
    push_in(32'h55, 1); push_in(32'h66, 0); push_in(32'h67, 1);
    push_ex(32'h55, 0, 4'hF); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 1, 4'h0);
    push_ex(32'h66, 0, 4'hF); push_ex(32'h67, 0, 4'hF); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 1, 4'h0);
    run(1'b0, 100);
    check("t3_rows", rows_done, 6);
    check("t3_pads", pad_words, 8);

    // 1000-word stream, random tlast, 50% downstream ready
    exp_rows = 6;
    exp_pads = 8;
    idx = 0;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      l = ($urandom_range(0, 4) == 0) || (i == 999);
      push_in(d, l);
      push_ex(d, idx == 3, 4'hF);
      if (idx == 3) exp_rows++;
      idx = (idx + 1) % 4;
      if (l) begin
        while (idx != 0) begin
          push_ex(32'h0, idx == 3, 4'h0);
          exp_pads++;
          if (idx == 3) exp_rows++;
          idx = (idx + 1) % 4;
        end
      end
    end
    run(1'b1, 20000);
    check("t4_rows", rows_done, 64'(exp_rows));
    check("t4_pads", pad_words, 64'(exp_pads));

    // Continuous 12 words without tlast: one per cycle after one cycle of latency
    for (int i = 1; i <= 12; i++) begin
      push_in(32'h100 + 32'(i), 0);
      push_ex(32'h100 + 32'(i), (i % 4) == 0, 4'hF);
    end
    run(1'b0, 100);
    check("t5_cycles", run_cycles, 13);
    check("t5_rows", rows_done, 64'(exp_rows + 3));
    check("t5_pads", pad_words, 64'(exp_pads));

    // Reset after 2 of 4 words, with a third word held in the output register
    push_in(32'h11, 0); push_in(32'h12, 0);
    push_ex(32'h11, 0, 4'hF); push_ex(32'h12, 0, 4'hF);
    run(1'b0, 50);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h13; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    @(posedge aclk);
    #1;
    check("r1_pre_vld", m_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    check("r1_vld", m_axis_tvalid, 0);
    check("r1_rows", rows_done, 0);
    check("r1_pads", pad_words, 0);
    check("r1_rdy", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      push_in(32'h20 + 32'(i), i == 4);
      push_ex(32'h20 + 32'(i), i == 4, 4'hF);
    end
    run(1'b0, 100);
    check("r1_after_rows", rows_done, 1);
    check("r1_after_pads", pad_words, 0);

    // Reset while padding
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h31; s_axis_tlast = 1'b1; m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge aclk);
    #1;
    check("r2_pre_padding", padding, 1);
    check("r2_pre_pads", pad_words, 1);
    aresetn = 1'b0;
    #1;
    check("r2_padding", padding, 0);
    check("r2_vld", m_axis_tvalid, 0);
    check("r2_rows", rows_done, 0);
    check("r2_pads", pad_words, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    push_in(32'h41, 0); push_in(32'h42, 1);
    push_ex(32'h41, 0, 4'hF); push_ex(32'h42, 0, 4'hF); push_ex(32'h0, 0, 4'h0); push_ex(32'h0, 1, 4'h0);
    run(1'b0, 100);
    check("r2_after_rows", rows_done, 1);
    check("r2_after_pads", pad_words, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_row_packer.md
Name: axis_row_packer

Overview:
- Upstream stage feeding the AXI-Stream-to-BRAM adapter's slave stream input.
- Re-frames an arbitrary-length AXI-Stream into fixed-size rows of ROW_WORDS words, each row ending with tlast, so every adapter write fills exactly one BRAM row.
- A short or ragged input frame is zero-padded (PAD_WORD) up to the next row boundary.
- One registered output stage; full throughput when downstream is always ready.

Parameters:
- DATA_WIDTH, 32: stream word width in bits; must match the adapter stream width.
- ROW_WORDS, 36: words per BRAM row; valid range 2..255.
- PAD_WORD, 0: DATA_WIDTH-bit value emitted for padding words.
- CNT_WIDTH, 16: width of the row and pad statistics counters.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  block can accept the input word.
- s_axis_tlast  in  1  last word of the input frame.
- m_axis_tdata  out  DATA_WIDTH  output word, to the adapter's s00 stream input.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accepts the output word.
- m_axis_tlast  out  1  last word of a row.
- m_axis_tstrb  out  DATA_WIDTH/8  all ones on data words, all zeros on pad words.
- rows_done  out  CNT_WIDTH  count of rows completed (handshaken with tlast).
- pad_words  out  CNT_WIDTH  count of pad words emitted.
- padding  out  1  high while state is PAD.

Behaviour:
- Reset (async assert, synchronous release on the next aclk edge):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0.
  - rows_done=0, pad_words=0, padding=0.
  - State=PASS, word_idx=0.
  - s_axis_tready=0 while aresetn is low.
- Handshakes:
  - Output handshake: m_axis_tvalid & m_axis_tready.
  - Input handshake: s_axis_tvalid & s_axis_tready.
  - Output register free: !m_axis_tvalid | m_axis_tready.
- s_axis_tready = (state==PASS) & output register free & aresetn. It is combinational and never depends on s_axis_tvalid.
- PASS state, on an input handshake:
  - The register loads tdata; tstrb is all ones; m_axis_tvalid=1.
  - m_axis_tlast = (word_idx==ROW_WORDS-1).
  - word_idx increments, wrapping to 0 after ROW_WORDS-1.
  - Latency is 1 cycle, input to output.
- Input frame end (s_axis_tlast on the handshake):
  - If word_idx==ROW_WORDS-1: the row closes naturally, no padding, stay in PASS.
  - Otherwise: next state is PAD, and the last data word goes out with m_axis_tlast=0.
- PAD state:
  - Whenever the output register is free, load PAD_WORD with tstrb=0 and m_axis_tlast=(word_idx==ROW_WORDS-1).
  - Increment word_idx and pad_words.
  - After loading the word with tlast, word_idx returns to 0 and the state returns to PASS.
  - No input is accepted in PAD.
- Long frames: input with no tlast across a row boundary still gets m_axis_tlast on every ROW_WORDS-th word. Rows are self-delimiting regardless of input framing.
- rows_done increments on every output handshake with m_axis_tlast=1.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- Backpressure:
  - m_axis_tdata, tlast and tstrb stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Simultaneous output handshake and input handshake in the same cycle: the register reloads, tvalid stays 1, with no bubble.
- Reset mid-row discards the partial row and any pending pad; there is no flush.
- Zero-length frames cannot occur (AXIS carries at least one word per frame).

Test Plan:
- ROW_WORDS=4, m_axis_tready=1, one frame 0x1..0x8 with tlast on 0x8 -> outputs 1..8, tlast on words 4 and 8, no pad, rows_done=2, pad_words=0.
- ROW_WORDS=4, frame 0xA,0xB,0xC,0xD,0xE with tlast on 0xE -> outputs A,B,C,D(tlast),E,0,0,0(tlast); tstrb=0xF on data and 0x0 on pads; pad_words=3; padding high 3 cycles; s_axis_tready=0 during PAD.
- ROW_WORDS=4, single-word frame 0x55 -> 0x55,0,0,0 with tlast on the 4th word; then a second frame 0x66,0x67(tlast) -> 0x66,0x67,0,0(tlast); rows_done=2.
- Random m_axis_tready (50%) over a 1000-word stream with random tlast -> output data/tlast/tstrb held stable under stall; tlast exactly every 4 words; sum of data words equals input count; rows_done equals total out/4.
- Continuous tvalid and tready for 12 words with no tlast -> one word per cycle after 1-cycle latency; tlast on words 4, 8, 12; rows_done=3.
- Assert aresetn low mid-row (after 2 of 4 words) and mid-PAD -> tvalid=0 and counters=0 immediately; the next frame starts at word_idx 0 with correct tlast placement.
